spi_wb_bridge: RTL
==================

# spi_wb_bridge

Wishbone B4 pipelined master driven by an SPI mode-0 target port from the host MCU. It is the stage directly upstream of `system`'s Wishbone peripheral port: it turns host SPI frames into single-byte RAM reads and writes with a 20-bit address and auto-increment. All SPI inputs are oversampled in the `wb_clock_i` domain; there is no second clock.

## Interface
Parameters:
- `WB_ADDR_WIDTH`, 20, Wishbone address width
- `DATA_WIDTH`, 8, Wishbone data width (SPI byte width)

Ports:
- `wb_clock_i`  in  1  sole clock; SPI sampled on it
- `wb_reset_i`  in  1  synchronous, active-high reset
- `spi_sck_i`  in  1  SPI clock, idle low (mode 0)
- `spi_cs_ni`  in  1  chip select, active low, frames a transaction
- `spi_sdi_i`  in  1  host→bridge data (MOSI), MSB first
- `spi_sdo_o`  out  1  bridge→host data (MISO), MSB first
- `spi_sdo_oe`  out  1  MISO drive enable, high while CS (synchronized) asserted
- `wb_addr_o`  out  WB_ADDR_WIDTH  transaction address
- `wb_data_o`  out  DATA_WIDTH  write data
- `wb_data_i`  in  DATA_WIDTH  read data, valid with `wb_ack_i`
- `wb_we_o`  out  1  1 = write
- `wb_cycle_o`  out  1  bus cycle
- `wb_strobe_o`  out  1  request strobe
- `wb_stall_i`  in  1  peripheral not accepting request
- `wb_ack_i`  in  1  transaction complete
- `overrun_o`  out  1  sticky: a byte requiring a WB transaction arrived while one was pending

## Operation
- Input sync: 2-flop synchronizer on SCK, CS_n and SDI, plus a third SCK/CS flop for edge detection. Rise/fall events are single-cycle pulses.
- Frame: CS_n falling clears the bit counter, byte index, `rd_data` (set to 0x00) and `overrun_o`.
  - Byte 0 = command: bit7 = W (1 write, 0 read), bits6:4 ignored, bits3:0 = addr[19:16].
  - Byte 1 = addr[15:8]; byte 2 = addr[7:0].
  - Bytes 3..n = data phase.
- Receive: on an SCK rise, shift SDI into `rx` and increment the 3-bit bit counter. When the counter wraps 7→0, the byte is complete.
- Transmit: while bit counter == 0, `spi_sdo_o` = `rd_data[7]`. On the first SCK rise of a byte, load `tx` = {`rd_data[6:0]`, 0}. On each SCK fall with bit counter ≠ 0, `tx` shifts left and `spi_sdo_o` = `tx[7]`.
- Data phase, write: each completed byte issues a WB write of `rx` at `addr`; then `addr` increments.
- Data phase, read: each completed byte (content ignored) issues a WB read at `addr`; then `addr` increments. The ack data is latched into `rd_data` and returned during the next byte. The first data byte returns 0x00.
- Address arithmetic: increment is modulo 2^20 (0xFFFFF → 0x00000).
- WB FSM states:
  - IDLE: cyc=0, stb=0. On a request, go to REQ and drive addr/we/data.
  - REQ: cyc=1, stb=1. When `wb_stall_i`=0, go to WAIT with stb=0.
  - WAIT: cyc=1, stb=0. On `wb_ack_i`, latch `wb_data_i` if reading and return to IDLE. Ack in the same cycle the strobe is accepted is legal.
- Overrun: a completed data byte while the FSM is not IDLE sets `overrun_o`. The new request is dropped and `addr` does not increment.
- CS_n rising mid-byte: discard the partial byte and reset the byte index. An in-flight WB transaction completes normally.
- Reset: the FSM goes to IDLE with every output 0, `spi_sdo_oe`=0 and `rd_data`=0x00. Reset aborts any in-flight transaction by dropping cyc/stb in the same cycle.

## Timing
- SCK high and low each ≥ 4 `wb_clock_i` cycles, so SCK ≤ 8 MHz at 64 MHz.
- An SCK or CS edge is acted on 3 cycles after it reaches the pin.
- A WB request asserts on the cycle after byte completion is detected.
- Host gap: ≥ 1.5 µs (96 cycles) from the last SCK rise of a data byte to the first SCK rise of the next byte. This covers worst-case `system` stall plus ack.
- CS_n setup/hold to the first/last SCK edge: ≥ 4 cycles.
- Outputs are registered, except that `spi_sdo_o` muxes `rd_data[7]` combinationally at a byte boundary.

## Test plan
- Reset: hold reset 4 cycles mid-frame → cyc, stb, we, sdo_oe, overrun all 0 the next cycle; the next frame decodes normally.
- Write burst: send 0x81 0x23 0x45 0xAA 0xBB with a 2 µs gap → writes 0xAA@0x12345 and 0xBB@0x12346, one cyc/stb each. With stall held 20 cycles, stb stays high until stall drops.
- Read burst: preload 0x11@0x00400 and 0x22@0x00401; send 0x00 0x04 0x00 then 3 dummy bytes → MISO returns 0x00, 0x11, 0x22.
- Wrap: write frame at 0xFFFFF with 2 data bytes → second write at 0x00000.
- Overrun: withhold ack and send 2 data bytes → overrun_o=1, no second request, addr unchanged. The next CS fall clears overrun.
- Abort: raise CS after 5 bits of byte 3 → no WB cycle. The next frame's byte 0 decodes as a command.

Source files
------------

// File: rtl/spi_wb_bridge.sv
// spi_wb_bridge: SPI mode-0 target issuing single-byte Wishbone B4 pipelined accesses with auto-increment
module spi_wb_bridge #(
  parameter int WB_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_i,
  input  logic                     spi_sck_i,
  input  logic                     spi_cs_ni,
  input  logic                     spi_sdi_i,
  output logic                     spi_sdo_o,
  output logic                     spi_sdo_oe,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  output logic                     wb_we_o,
  output logic                     wb_cycle_o,
  output logic                     wb_strobe_o,
  input  logic                     wb_stall_i,
  input  logic                     wb_ack_i,
  output logic                     overrun_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state;
  logic [2:0] sck_s, cs_s, bit_cnt;
  logic [1:0] sdi_s, byte_idx;
  logic [DATA_WIDTH-1:0] rx, tx, rd_data, rx_next;
  logic [WB_ADDR_WIDTH-1:0] addr;
  logic we_cmd, sdo_r, cs_act, sck_rise, sck_fall, cs_fall, cs_rise, ack_ok;
  assign cs_act = ~cs_s[1];
  assign sck_rise = cs_act & sck_s[1] & ~sck_s[2];
  assign sck_fall = cs_act & ~sck_s[1] & sck_s[2];
  assign cs_fall = ~cs_s[1] & cs_s[2];
  assign cs_rise = cs_s[1] & ~cs_s[2];
  assign rx_next = {rx[DATA_WIDTH-2:0], sdi_s[1]};
  assign ack_ok = wb_ack_i & ((state == WAIT) | ((state == REQ) & ~wb_stall_i));
  assign spi_sdo_o = (bit_cnt == 3'd0) ? rd_data[DATA_WIDTH-1] : sdo_r;
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      state <= IDLE;
      sck_s <= '0;
      cs_s <= '1;
      sdi_s <= '0;
      bit_cnt <= '0;
      byte_idx <= '0;
      rx <= '0;
      tx <= '0;
      rd_data <= '0;
      addr <= '0;
      we_cmd <= 1'b0;
      sdo_r <= 1'b0;
      spi_sdo_oe <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_we_o <= 1'b0;
      wb_cycle_o <= 1'b0;
      wb_strobe_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      sck_s <= {sck_s[1:0], spi_sck_i};
      cs_s <= {cs_s[1:0], spi_cs_ni};
      sdi_s <= {sdi_s[0], spi_sdi_i};
      spi_sdo_oe <= cs_act;
      if (sck_rise) begin
        rx <= rx_next;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd0) begin
          tx <= {rd_data[DATA_WIDTH-2:0], 1'b0};
          sdo_r <= rd_data[DATA_WIDTH-1];
        end
        if (bit_cnt == 3'd7) begin
          byte_idx <= (byte_idx == 2'd3) ? byte_idx : byte_idx + 2'd1;
          case (byte_idx)
            2'd0: begin
              we_cmd <= rx_next[DATA_WIDTH-1];
              addr[WB_ADDR_WIDTH-1:16] <= rx_next[WB_ADDR_WIDTH-17:0];
            end
            2'd1: addr[15:8] <= rx_next;
            2'd2: addr[7:0] <= rx_next;
            default: begin
              if (state == IDLE) begin
                state <= REQ;
                wb_cycle_o <= 1'b1;
                wb_strobe_o <= 1'b1;
                wb_addr_o <= addr;
                wb_we_o <= we_cmd;
                wb_data_o <= rx_next;
                addr <= addr + WB_ADDR_WIDTH'(1);
              end else overrun_o <= 1'b1;
            end
          endcase
        end
      end
      if (sck_fall && bit_cnt != 3'd0) begin
        sdo_r <= tx[DATA_WIDTH-1];
        tx <= {tx[DATA_WIDTH-2:0], 1'b0};
      end
      case (state)
        REQ: if (!wb_stall_i) begin
          wb_strobe_o <= 1'b0;
          wb_cycle_o <= ~wb_ack_i;
          state <= wb_ack_i ? IDLE : WAIT;
        end
        WAIT: if (wb_ack_i) begin
          wb_cycle_o <= 1'b0;
          state <= IDLE;
        end
        default: ;
      endcase
      if (ack_ok && !wb_we_o) rd_data <= wb_data_i;
      if (cs_rise) begin
        bit_cnt <= '0;
        byte_idx <= '0;
      end
      if (cs_fall) begin
        bit_cnt <= '0;
        byte_idx <= '0;
        rd_data <= '0;
        overrun_o <= 1'b0;
      end
    end
  end
endmodule
